// File: rtl/intersection_phase_controller_if.sv
// intersection_phase_controller_if: sensor/button inputs and lamp outputs of the phase controller
//   master: front end / bench side (drives tick and requests, observes lamps)
//   slave : controller side (consumes tick and requests, drives lamps and status)
interface intersection_phase_controller_if;
  logic       tick;
  logic       ns_req;
  logic       ew_req;
  logic       ped_req;
  logic       ns_green;
  logic       ns_yellow;
  logic       ns_red;
  logic       ew_green;
  logic       ew_yellow;
  logic       ew_red;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;
  modport master (
    output tick, ns_req, ew_req, ped_req,
    input  ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, ped_pending, phase
  );
  modport slave (
    input  tick, ns_req, ew_req, ped_req,
    output ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, ped_pending, phase
  );
endinterface

// File: rtl/intersection_phase_controller.sv
// intersection_phase_controller: demand-driven NS/EW phase scheduler with pedestrian WALK on the EW phase
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : tick and ns/ew/ped requests in; six lamp drives, walk, ped_pending and phase code out
module intersection_phase_controller #(
  parameter int CW        = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input logic                          clk,
  input logic                          reset,
  intersection_phase_controller_if.slave bus
);
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_t;
  localparam logic [CW-1:0] GMIN1 = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX1 = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL1  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALR1  = CW'(ALLRED_T - 1);
  state_t          state_q, state_d, nxt;
  logic [CW-1:0]   timer_q, timer_d;
  logic            ped_q, ped_d, walk_q, walk_d, go, enter_ew;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= NS_GREEN;
      timer_q <= '0;
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
      walk_q  <= walk_d;
    end
  always_comb begin
    nxt = NS_GREEN;
    go  = 1'b1;
    case (state_q)
      NS_GREEN:  begin nxt = NS_YELLOW; go = timer_q >= GMIN1 && (bus.ew_req || ped_q); end
      NS_YELLOW: begin nxt = ALLRED_A;  go = timer_q == YEL1; end
      ALLRED_A:  begin nxt = EW_GREEN;  go = timer_q == ALR1; end
      EW_GREEN:  begin nxt = EW_YELLOW; go = timer_q == GMAX1 || (timer_q >= GMIN1 && (bus.ns_req || !bus.ew_req)); end
      EW_YELLOW: begin nxt = ALLRED_B;  go = timer_q == YEL1; end
      ALLRED_B:  begin nxt = NS_GREEN;  go = timer_q == ALR1; end
      default:   ;
    endcase
    // illegal codes recover to NS_GREEN on the next clk, tick or not
    go       = go && (bus.tick || state_q > ALLRED_B);
    state_d  = go ? nxt : state_q;
    timer_d  = go ? '0 : (!bus.tick || timer_q == GMAX1) ? timer_q : timer_q + 1'b1;
    enter_ew = go && nxt == EW_GREEN;
    // a request on the entry clk survives the clear and is served next round
    ped_d    = bus.ped_req || (ped_q && !enter_ew);
    walk_d   = enter_ew ? ped_q : walk_q && !go;
  end
  assign bus.ns_green    = state_q == NS_GREEN;
  assign bus.ns_yellow   = state_q == NS_YELLOW;
  assign bus.ns_red      = !(state_q inside {NS_GREEN, NS_YELLOW});
  assign bus.ew_green    = state_q == EW_GREEN;
  assign bus.ew_yellow   = state_q == EW_YELLOW;
  assign bus.ew_red      = !(state_q inside {EW_GREEN, EW_YELLOW});
  assign bus.walk        = walk_q;
  assign bus.ped_pending = ped_q;
  assign bus.phase       = state_q;
endmodule

// File: tb/tb_intersection_phase_controller.sv
// tb_intersection_phase_controller: directed self-checking bench for the intersection phase controller
module tb_intersection_phase_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  intersection_phase_controller_if bus();
  intersection_phase_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  wire [5:0] lamps = {bus.ns_green, bus.ns_yellow, bus.ns_red, bus.ew_green, bus.ew_yellow, bus.ew_red};
  function automatic logic [5:0] lamps_for(input logic [2:0] p);
    case (p)
      3'd0:    return 6'b100_001;
      3'd1:    return 6'b010_001;
      3'd3:    return 6'b001_100;
      3'd4:    return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction
  function automatic logic [2:0] exp_ew(input int k);
    if (k < 4)  return 3'd0;
    if (k < 6)  return 3'd1;
    if (k < 7)  return 3'd2;
    if (k < 19) return 3'd3;
    if (k < 21) return 3'd4;
    if (k < 22) return 3'd5;
    return 3'd0;
  endfunction
  task automatic step(input logic t);
    bus.tick = t;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask
  task automatic do_reset();
    bus.tick = 0; bus.ns_req = 0; bus.ew_req = 0; bus.ped_req = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask
  task automatic test_reset();
    bus.tick = 0; bus.ns_req = 0; bus.ew_req = 1; bus.ped_req = 1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", bus.phase); end
    checks++; if (lamps !== 6'b100_001) begin failures++; $display("FAIL reset_lamps got=%b exp=100001", lamps); end
    checks++; if (bus.walk !== 1'b0) begin failures++; $display("FAIL reset_walk got=%b exp=0", bus.walk); end
    checks++; if (bus.ped_pending !== 1'b0) begin failures++; $display("FAIL reset_ped got=%b exp=0", bus.ped_pending); end
  endtask
  task automatic test_no_demand();
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      step(1'b1);
      checks++; if (bus.phase !== 3'd0 || lamps !== 6'b100_001) begin failures++; $display("FAIL no_demand tick=%0d phase=%0d lamps=%b exp phase=0 lamps=100001", k, bus.phase, lamps); end
    end
  endtask
  task automatic test_ew_demand(input int gap);
    do_reset();
    bus.ew_req = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      for (int g = 1; g < gap; g++) begin
        step(1'b0);
        checks++; if (bus.phase !== exp_ew(k - 1)) begin failures++; $display("FAIL ew_idle gap=%0d tick=%0d got=%0d exp=%0d", gap, k, bus.phase, exp_ew(k - 1)); end
      end
      step(1'b1);
      checks++; if (bus.phase !== exp_ew(k)) begin failures++; $display("FAIL ew_phase gap=%0d tick=%0d got=%0d exp=%0d", gap, k, bus.phase, exp_ew(k)); end
      checks++; if (lamps !== lamps_for(exp_ew(k))) begin failures++; $display("FAIL ew_lamps gap=%0d tick=%0d got=%b exp=%b", gap, k, lamps, lamps_for(exp_ew(k))); end
    end
    bus.ew_req = 1'b0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.ew_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus.ped_req = (k == 10);
      step(1'b1);
      bus.ped_req = 1'b0;
    end
    checks++; if (bus.phase !== 3'd4 || bus.ped_pending !== 1'b1) begin failures++; $display("FAIL mid_pre phase=%0d ped=%b exp phase=4 ped=1", bus.phase, bus.ped_pending); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.phase !== 3'd0 || lamps !== 6'b100_001) begin failures++; $display("FAIL mid_reset phase=%0d lamps=%b exp phase=0 lamps=100001", bus.phase, lamps); end
    checks++; if (bus.ped_pending !== 1'b0 || bus.walk !== 1'b0) begin failures++; $display("FAIL mid_reset_ped ped=%b walk=%b exp 0 0", bus.ped_pending, bus.walk); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.ew_req = 1'b0;
  endtask
  task automatic test_ped_only();
    do_reset();
    bus.ped_req = 1'b1;
    step(1'b0);
    bus.ped_req = 1'b0;
    checks++; if (bus.ped_pending !== 1'b1) begin failures++; $display("FAIL ped_latch got=%b exp=1", bus.ped_pending); end
    for (int k = 1; k <= 12; k++) begin
      logic [2:0] ep;
      ep = k < 4 ? 3'd0 : k < 6 ? 3'd1 : k < 7 ? 3'd2 : k < 11 ? 3'd3 : 3'd4;
      step(1'b1);
      checks++; if (bus.phase !== ep) begin failures++; $display("FAIL ped_phase tick=%0d got=%0d exp=%0d", k, bus.phase, ep); end
      checks++; if (bus.ped_pending !== (k < 7)) begin failures++; $display("FAIL ped_pending tick=%0d got=%b exp=%b", k, bus.ped_pending, k < 7); end
      checks++; if (bus.walk !== (k >= 7 && k < 11)) begin failures++; $display("FAIL ped_walk tick=%0d got=%b exp=%b", k, bus.walk, k >= 7 && k < 11); end
    end
  endtask
  task automatic test_coincident();
    do_reset();
    bus.ped_req = 1'b1;
    step(1'b0);
    bus.ped_req = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      bus.ped_req = (k == 7);
      step(1'b1);
      bus.ped_req = 1'b0;
      if (k == 7) begin
        checks++; if (bus.phase !== 3'd3 || bus.walk !== 1'b1 || bus.ped_pending !== 1'b1) begin failures++; $display("FAIL coin_entry phase=%0d walk=%b ped=%b exp 3 1 1", bus.phase, bus.walk, bus.ped_pending); end
      end
      if (k == 11) begin
        checks++; if (bus.phase !== 3'd4 || bus.walk !== 1'b0 || bus.ped_pending !== 1'b1) begin failures++; $display("FAIL coin_exit phase=%0d walk=%b ped=%b exp 4 0 1", bus.phase, bus.walk, bus.ped_pending); end
      end
      if (k == 14) begin
        checks++; if (bus.phase !== 3'd0) begin failures++; $display("FAIL coin_ns got=%0d exp=0", bus.phase); end
      end
      if (k == 21) begin
        checks++; if (bus.phase !== 3'd3 || bus.walk !== 1'b1 || bus.ped_pending !== 1'b0) begin failures++; $display("FAIL coin_second phase=%0d walk=%b ped=%b exp 3 1 0", bus.phase, bus.walk, bus.ped_pending); end
      end
    end
  endtask
  task automatic test_cross();
    do_reset();
    bus.ew_req = 1'b1;
    repeat (7) step(1'b1);
    checks++; if (bus.phase !== 3'd3) begin failures++; $display("FAIL cross_enter got=%0d exp=3", bus.phase); end
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) bus.ns_req = 1'b1;
      step(1'b1);
      checks++; if (bus.phase !== (k < 4 ? 3'd3 : 3'd4)) begin failures++; $display("FAIL cross tick=%0d got=%0d exp=%0d", k, bus.phase, k < 4 ? 3'd3 : 3'd4); end
    end
    bus.ns_req = 1'b0;
    bus.ew_req = 1'b0;
  endtask
  initial begin
    test_reset();
    test_no_demand();
    test_ew_demand(1);
    test_ew_demand(3);
    test_reset_mid();
    test_ped_only();
    test_coincident();
    test_cross();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/intersection_phase_controller.md
Name: intersection_phase_controller

Overview:
- Sequences the two-way intersection lights: north-south (NS) and east-west (EW) heads, plus a pedestrian crossing on the EW phase.
- Replaces free-running light timing with a demand-driven phase scheduler. Phases have minimum and maximum green times, a yellow interval and an all-red clearance.
- Sits between the sensor/button front end and the lamp drivers.
- All timing counts `tick` pulses from an external prescaler, not raw clocks.

Parameters:
- CW, 4, width of the phase timer.
- GREEN_MIN, 4, minimum green duration in ticks (≥1).
- GREEN_MAX, 12, maximum green duration in ticks (≥GREEN_MIN).
- YELLOW_T, 2, yellow duration in ticks (≥1).
- ALLRED_T, 1, all-red clearance duration in ticks (≥1).
- All durations must be ≤ 2^CW.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle timing enable; the timer advances only when it is 1.
- ns_req  in  1  NS vehicle sensor (level).
- ew_req  in  1  EW vehicle sensor (level).
- ped_req  in  1  pedestrian button (pulse or level, sampled every clk).
- ns_green, ns_yellow, ns_red  out  1 each  NS lamp drives.
- ew_green, ew_yellow, ew_red  out  1 each  EW lamp drives.
- walk  out  1  pedestrian WALK lamp.
- ped_pending  out  1  latched, unserved pedestrian request.
- phase  out  3  current state encoding.

Behaviour:
- States and `phase` encoding: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5. Codes 6 and 7 are illegal and go to NS_GREEN on the next clk.
- Reset (reset=0, asynchronous, no clk needed):
  - state=NS_GREEN, timer=0, ped_pending=0, walk=0.
  - Therefore ns_green=1, ew_red=1, all other lamps 0.
- Lamp outputs are decoded from the state register only (Moore):
  - NS_GREEN: ns_green=1, ew_red=1.
  - NS_YELLOW: ns_yellow=1, ew_red=1.
  - ALLRED_A and ALLRED_B: ns_red=1, ew_red=1.
  - EW_GREEN: ns_red=1, ew_green=1.
  - EW_YELLOW: ns_red=1, ew_yellow=1.
  - Exactly one lamp per head is 1 at all times.
- Timer:
  - When tick=0, state and timer hold.
  - On a tick with no transition, timer increments, saturating at GREEN_MAX-1.
  - Timer clears to 0 on every state change.
  - "Lasts N ticks" means the transition happens on the tick where timer==N-1.
- Transitions (evaluated only on tick=1):
  - NS_GREEN → NS_YELLOW when timer≥GREEN_MIN-1 and (ew_req | ped_pending). With no demand, NS_GREEN holds indefinitely.
  - NS_YELLOW → ALLRED_A when timer==YELLOW_T-1.
  - ALLRED_A → EW_GREEN when timer==ALLRED_T-1.
  - EW_GREEN → EW_YELLOW in either of two cases:
    - timer≥GREEN_MIN-1 and (ns_req | !ew_req);
    - timer==GREEN_MAX-1, regardless of requests.
  - EW_YELLOW → ALLRED_B when timer==YELLOW_T-1.
  - ALLRED_B → NS_GREEN when timer==ALLRED_T-1.
- Pedestrian handling:
  - ped_pending sets on any clk where ped_req=1.
  - On entry to EW_GREEN: walk ← ped_pending, and ped_pending clears.
  - If ped_req=1 on the same clk as that entry, ped_pending stays 1; set wins over clear. That request is served next cycle round.
  - walk clears on the transition out of EW_GREEN; walk=1 only while in EW_GREEN.
  - A ped_req during EW_GREEN latches ped_pending but does not extend or assert walk.
- Reset mid-phase: immediate return to reset values. Any pending pedestrian request is lost.

Test Plan (default parameters; "tick k" = k-th tick pulse after reset release):
- Reset: hold reset=0, toggle clk → phase=0, ns_green=1, ew_red=1, walk=0, ped_pending=0. Assert reset=0 between clk edges while in phase 4 → outputs go to reset values before the next edge.
- No demand: ns_req=ew_req=ped_req=0, 50 ticks → phase stays 0, lamps unchanged.
- EW demand, held: ew_req=1, ns_req=0 from reset. Expected phase sequence:
  - phase 1 after tick 4, phase 2 after tick 6, phase 3 after tick 7;
  - EW_GREEN held to GREEN_MAX, so phase 4 after tick 19;
  - phase 5 after tick 21, phase 0 after tick 22.
- Tick gaps: repeat the EW demand case with tick asserted every 3rd clk → identical tick-indexed sequence, with state stable on non-tick cycles.
- Pedestrian only: 1-clk ped_req pulse at reset release, ew_req=0. Expected:
  - ped_pending=1 until phase 3 entry (after tick 7), then 0;
  - walk=1 for all of EW_GREEN;
  - EW_GREEN exits after GREEN_MIN=4 ticks (!ew_req), so phase 4 after tick 11;
  - walk=0 in phase 4.
- Coincident pedestrian request: ped_req asserted on the exact clk of ALLRED_A → EW_GREEN. Expected walk=1 and ped_pending still 1 afterwards; the next EW_GREEN also asserts walk.
- Cross demand: in EW_GREEN with ew_req=1, raise ns_req at tick 2 of the phase → EW_YELLOW exactly at the GREEN_MIN boundary (timer==3), not earlier.
